// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Build option: RF_WB_LAT_BYPASS_EN (same-cycle long-latency writes).
package rf_wb_pkg;

   localparam int       NREGS  = 32;
   localparam int       XLEN   = 32;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef logic [4:0] regaddr_t;

   typedef struct packed {
      regaddr_t        rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writer-side bundle: pipeline W stage, long-latency unit,
// issue/decode scoreboard queries and the regfile write port.
interface rf_wb_arbiter_if #(
   parameter int WIDTH = 32
);
   import rf_wb_pkg::*;

   logic             RegWriteW;
   regaddr_t         RdW;
   logic [WIDTH-1:0] ResultW;

   logic             lat_valid;
   regaddr_t         lat_rd;
   logic [WIDTH-1:0] lat_data;
   logic             lat_ready;

   logic             issue_valid;
   regaddr_t         issue_rd;
   logic             issue_stall;

   regaddr_t         ra1;
   regaddr_t         ra2;
   logic             busy1;
   logic             busy2;

   logic             we3;
   regaddr_t         wa3;
   logic [WIDTH-1:0] wd3;

   modport master (
      output RegWriteW, RdW, ResultW,
      output lat_valid, lat_rd, lat_data,
      input  lat_ready,
      output issue_valid, issue_rd,
      input  issue_stall,
      output ra1, ra2,
      input  busy1, busy2,
      input  we3, wa3, wd3
   );

   modport slave (
      input  RegWriteW, RdW, ResultW,
      input  lat_valid, lat_rd, lat_data,
      output lat_ready,
      input  issue_valid, issue_rd,
      output issue_stall,
      input  ra1, ra2,
      output busy1, busy2,
      output we3, wa3, wd3
   );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous DEPTH-entry FIFO holding pending long-latency writes.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = wb_req_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp];

   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges pipeline and long-latency writes onto regfile port 3 and
// tracks outstanding long writes. Option: RF_WB_LAT_BYPASS_EN.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           reset,
   rf_wb_arbiter_if.slave bus
);

   typedef struct packed {
      regaddr_t         rd;
      logic [WIDTH-1:0] data;
   } req_t;

   req_t             din;
   req_t             dout;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             bypass;
   logic             accept;
   logic             pipe_w;
   logic             lat_rdy;
   logic             lat_w;
   logic             set_b;
   logic             stall;
   logic             we;
   regaddr_t         wa;
   logic [WIDTH-1:0] wd;
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   assign lat_rdy = !reset && !full;
   assign accept  = bus.lat_valid && lat_rdy;
   assign pipe_w  = !reset && bus.RegWriteW && (bus.RdW != REG_X0);

`ifdef RF_WB_LAT_BYPASS_EN
   assign bypass = accept && empty && !pipe_w &&
                   (bus.lat_rd != REG_X0);
`else
   assign bypass = 1'b0;
`endif

   // x0 results are consumed at acceptance and never queued
   assign push = accept && !bypass && (bus.lat_rd != REG_X0);
   assign pop  = !reset && !empty && !pipe_w;

   always_comb begin
      din      = '0;
      din.rd   = bus.lat_rd;
      din.data = bus.lat_data;
   end

   rf_wb_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      we = 1'b0;
      wa = REG_X0;
      wd = '0;
      unique case (1'b1)
         pipe_w: begin
            we = 1'b1;
            wa = bus.RdW;
            wd = bus.ResultW;
         end
         pop: begin
            we = 1'b1;
            wa = dout.rd;
            wd = dout.data;
         end
         bypass: begin
            we = 1'b1;
            wa = bus.lat_rd;
            wd = bus.lat_data;
         end
         default: ;
      endcase
   end

   assign lat_w = pop || bypass;
   assign stall = !reset && bus.issue_valid &&
                  busy_q[bus.issue_rd];
   assign set_b = !reset && bus.issue_valid && !stall &&
                  (bus.issue_rd != REG_X0);

   // set after clear so a same-cycle set on the same register wins
   always_comb begin
      busy_d = busy_q;
      if (lat_w) busy_d[wa] = 1'b0;
      if (set_b) busy_d[bus.issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign bus.we3         = we;
   assign bus.wa3         = wa;
   assign bus.wd3         = wd;
   assign bus.lat_ready   = lat_rdy;
   assign bus.issue_stall = stall;
   assign bus.busy1       = !reset && busy_q[bus.ra1];
   assign bus.busy2       = !reset && busy_q[bus.ra2];

   a_pipe_busy: assert property (
      @(posedge clk) disable iff (reset)
      !(pipe_w && busy_q[bus.RdW])
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with an expected-write queue.
// Expectations follow RF_WB_LAT_BYPASS_EN when it is defined.
module tb_rf_wb_arbiter;

`ifdef RF_WB_LAT_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ex_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   ex_t  q[$];
   ex_t  e;

   rf_wb_arbiter_if #(.WIDTH(32)) bus ();

   rf_wb_arbiter #(
      .DEPTH (2),
      .WIDTH (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.RegWriteW   = 1'b0;
      bus.RdW         = 5'd0;
      bus.ResultW     = 32'd0;
      bus.lat_valid   = 1'b0;
      bus.lat_rd      = 5'd0;
      bus.lat_data    = 32'd0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 5'd0;
   endtask

   task automatic expw(input logic [4:0] a, input logic [31:0] d);
      ex_t x;
      x.a = a;
      x.d = d;
      q.push_back(x);
   endtask

   // every port write must match the next expected write
   always @(negedge clk) begin
      if (bus.we3 === 1'b1) begin
         chk("sb_has_entry", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_wa3", 32'(bus.wa3), 32'(e.a));
            chk("sb_wd3", bus.wd3, e.d);
         end
      end
   end

   initial begin
      reset = 1'b1;
      idle();
      bus.ra1       = 5'd5;
      bus.ra2       = 5'd0;
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd1;
      bus.lat_data  = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_we3", 32'(bus.we3), 32'd0);
         chk("rst_lat_ready", 32'(bus.lat_ready), 32'd0);
         chk("rst_busy1", 32'(bus.busy1), 32'd0);
         chk("rst_busy2", 32'(bus.busy2), 32'd0);
         tick();
      end
      reset = 1'b0;
      idle();
      @(negedge clk);
      chk("rel_lat_ready", 32'(bus.lat_ready), 32'd1);
      tick();

      // issue rd=5, result four cycles later
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd5;
      @(negedge clk);
      chk("b_stall0", 32'(bus.issue_stall), 32'd0);
      chk("b_busy_pre", 32'(bus.busy1), 32'd0);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("b_busy_wait", 32'(bus.busy1), 32'd1);
         tick();
      end
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd5;
      bus.lat_data  = 32'hDEADBEEF;
      expw(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      chk("b_we3_accept", 32'(bus.we3), 32'(BYP));
      chk("b_lat_ready", 32'(bus.lat_ready), 32'd1);
      chk("b_busy_acc", 32'(bus.busy1), 32'd1);
      tick();
      idle();
      @(negedge clk);
      chk("b_we3_next", 32'(bus.we3), 32'(!BYP));
      chk("b_busy_next", 32'(bus.busy1), 32'(!BYP));
      tick();
      @(negedge clk);
      chk("b_we3_done", 32'(bus.we3), 32'd0);
      chk("b_busy_done", 32'(bus.busy1), 32'd0);
      tick();

      // pipeline priority and buffer ordering
      bus.RegWriteW = 1'b1;
      bus.RdW       = 5'd3;
      bus.ResultW   = 32'h11;
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd7;
      bus.lat_data  = 32'hA;
      expw(5'd3, 32'h11);
      @(negedge clk);
      chk("c_ready0", 32'(bus.lat_ready), 32'd1);
      tick();
      bus.RdW      = 5'd4;
      bus.ResultW  = 32'h22;
      bus.lat_rd   = 5'd8;
      bus.lat_data = 32'hB;
      expw(5'd4, 32'h22);
      expw(5'd7, 32'hA);
      expw(5'd8, 32'hB);
      @(negedge clk);
      chk("c_ready1", 32'(bus.lat_ready), 32'd1);
      tick();
      idle();
      @(negedge clk);
      chk("c_ready_full", 32'(bus.lat_ready), 32'd0);
      chk("c_we3_pop7", 32'(bus.we3), 32'd1);
      tick();
      @(negedge clk);
      chk("c_ready_one", 32'(bus.lat_ready), 32'd1);
      tick();
      @(negedge clk);
      chk("c_we3_idle", 32'(bus.we3), 32'd0);
      tick();

      // WAW stall on rd=9
      bus.ra1         = 5'd9;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd9;
      @(negedge clk);
      chk("d_stall_free", 32'(bus.issue_stall), 32'd0);
      tick();
      @(negedge clk);
      chk("d_stall_busy", 32'(bus.issue_stall), 32'd1);
      chk("d_busy1", 32'(bus.busy1), 32'd1);
      tick();
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd9;
      bus.lat_data  = 32'h99;
      expw(5'd9, 32'h99);
      @(negedge clk);
      chk("d_stall_acc", 32'(bus.issue_stall), 32'd1);
      tick();
      bus.lat_valid = 1'b0;
      @(negedge clk);
      chk("d_stall_clr", 32'(bus.issue_stall), 32'(!BYP));
      tick();
      @(negedge clk);
      chk("d_stall_after", 32'(bus.issue_stall), 32'(BYP));
      tick();
      idle();
      @(negedge clk);
      chk("d_busy_reset", 32'(bus.busy1), 32'd1);
      tick();
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd9;
      bus.lat_data  = 32'h77;
      expw(5'd9, 32'h77);
      tick();
      idle();
      tick();
      tick();
      @(negedge clk);
      chk("d_busy_final", 32'(bus.busy1), 32'd0);
      tick();

      // RdW=0 yields the port; x0 result is dropped
      bus.RegWriteW = 1'b1;
      bus.RdW       = 5'd2;
      bus.ResultW   = 32'h2;
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd10;
      bus.lat_data  = 32'hA0;
      expw(5'd2, 32'h2);
      tick();
      bus.RdW       = 5'd0;
      bus.ResultW   = 32'hBAD;
      bus.lat_valid = 1'b0;
      expw(5'd10, 32'hA0);
      @(negedge clk);
      chk("e_we3_x0pipe", 32'(bus.we3), 32'd1);
      chk("e_wa3_x0pipe", 32'(bus.wa3), 32'd10);
      tick();
      idle();
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd0;
      bus.lat_data  = 32'h5;
      @(negedge clk);
      chk("e_ready_x0", 32'(bus.lat_ready), 32'd1);
      chk("e_we3_x0", 32'(bus.we3), 32'd0);
      tick();
      idle();
      @(negedge clk);
      chk("e_we3_after", 32'(bus.we3), 32'd0);
      tick();

      // fill buffer, then reset mid-operation
      bus.ra1         = 5'd7;
      bus.ra2         = 5'd8;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd7;
      tick();
      bus.issue_rd = 5'd8;
      tick();
      idle();
      bus.RegWriteW = 1'b1;
      bus.RdW       = 5'd1;
      bus.ResultW   = 32'h1;
      bus.lat_valid = 1'b1;
      bus.lat_rd    = 5'd7;
      bus.lat_data  = 32'h70;
      expw(5'd1, 32'h1);
      tick();
      bus.RdW      = 5'd2;
      bus.ResultW  = 32'h2;
      bus.lat_rd   = 5'd8;
      bus.lat_data = 32'h80;
      expw(5'd2, 32'h2);
      @(negedge clk);
      chk("f_busy7", 32'(bus.busy1), 32'd1);
      chk("f_busy8", 32'(bus.busy2), 32'd1);
      tick();
      idle();
      reset = 1'b1;
      @(negedge clk);
      chk("f_rst_we3", 32'(bus.we3), 32'd0);
      chk("f_rst_ready", 32'(bus.lat_ready), 32'd0);
      chk("f_rst_busy1", 32'(bus.busy1), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("f_post_busy1", 32'(bus.busy1), 32'd0);
      chk("f_post_busy2", 32'(bus.busy2), 32'd0);
      chk("f_post_ready", 32'(bus.lat_ready), 32'd1);
      chk("f_post_we3", 32'(bus.we3), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("f_quiet_we3", 32'(bus.we3), 32'd0);
      end
      tick();
      chk("sb_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
